// File: rtl/montar_pin_param.sv
// PIN-entry assembler for the door-lock datapath.
// Collects BCD key codes into a shift buffer (nibble 0 = newest digit), with
// backspace, clear, enter, minimum-length check and an inactivity timeout.
// A completed PIN is held with pin_valid until the consumer returns pin_ack.
module montar_pin_param #(
    parameter int          MAX_DIGITS     = 4,
    parameter int          MIN_DIGITS     = 4,
    parameter int          TIMEOUT_CYCLES = 50,
    parameter logic [3:0]  KEY_BACK       = 4'hA,
    parameter logic [3:0]  KEY_CLEAR      = 4'hE,
    parameter logic [3:0]  KEY_ENTER      = 4'hF
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             key_valid,
    input  logic [3:0]                       key_code,
    input  logic                             pin_ack,
    output logic [4*MAX_DIGITS-1:0]          pin_digits,
    output logic [$clog2(MAX_DIGITS+1)-1:0]  pin_len,
    output logic                             pin_valid,
    output logic                             busy,
    output logic                             err,
    output logic                             timeout
);

    localparam int LEN_W = $clog2(MAX_DIGITS + 1);
    localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [LEN_W-1:0]        MAX_LEN  = LEN_W'(MAX_DIGITS);
    localparam logic [LEN_W-1:0]        MIN_LEN  = LEN_W'(MIN_DIGITS);
    localparam logic [LEN_W-1:0]        ONE_LEN  = LEN_W'(1);
    localparam bit                      TIMER_EN = (TIMEOUT_CYCLES > 0);
    localparam logic [TMR_W-1:0]        TMR_LAST = (TIMEOUT_CYCLES > 0) ? TMR_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [4*MAX_DIGITS-1:0] EMPTY    = {MAX_DIGITS{4'hF}};

    typedef enum logic [1:0] {
        ST_IDLE,   // buffer empty
        ST_ENTRY,  // digits being typed, inactivity timer running
        ST_READY   // completed PIN frozen, waiting for pin_ack
    } state_t;

    // Registered state
    state_t                  r_state;
    logic [4*MAX_DIGITS-1:0] r_digits;
    logic [LEN_W-1:0]        r_len;
    logic [TMR_W-1:0]        r_timer;
    logic                    r_valid;
    logic                    r_busy;
    logic                    r_err;
    logic                    r_timeout;
    logic                    r_key_valid_d;

    // Combinational next values
    state_t                  w_next_state;
    logic [4*MAX_DIGITS-1:0] w_digits_nxt;
    logic [LEN_W-1:0]        w_len_nxt;
    logic [TMR_W-1:0]        w_timer_nxt;
    logic                    w_err_nxt;
    logic                    w_timeout_nxt;
    logic                    w_accept;
    logic                    w_key_event;
    logic                    w_is_digit;
    logic [4*MAX_DIGITS-1:0] w_shift_up;
    logic [4*MAX_DIGITS-1:0] w_shift_down;

    // A press fires once, on the rising edge of the held key level.
    assign w_key_event = key_valid & ~r_key_valid_d;
    assign w_is_digit  = (key_code <= 4'd9);

    // Candidate buffers for a new digit (shift up) and for backspace (shift down).
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        w_shift_up   = r_digits;
        w_shift_down = r_digits;
        w_shift_up[3:0] = key_code;
        for (int i = 1; i < MAX_DIGITS; i++) begin
            w_shift_up[4*i +: 4] = r_digits[4*(i-1) +: 4];
        end
        for (int i = 0; i < MAX_DIGITS - 1; i++) begin
            w_shift_down[4*i +: 4] = r_digits[4*(i+1) +: 4];
        end
        w_shift_down[4*MAX_DIGITS-4 +: 4] = 4'hF;
    end

    // State register and key-level history.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst) begin
            r_state       <= ST_IDLE;
            // Starts high so a key already held when reset releases is not taken as a press.
            r_key_valid_d <= 1'b1;
        end else begin
            r_state       <= w_next_state;
            r_key_valid_d <= key_valid;
        end
    end

    // Next-state, buffer and timer decisions for the current key event / ack / timer.
    always_comb begin
        w_next_state  = r_state;
        w_digits_nxt  = r_digits;
        w_len_nxt     = r_len;
        w_timer_nxt   = r_timer;
        w_err_nxt     = 1'b0;
        w_timeout_nxt = 1'b0;
        w_accept      = 1'b0;

        unique case (r_state)
            ST_IDLE, ST_ENTRY: begin
                if (w_key_event) begin
                    if (w_is_digit) begin
                        w_accept     = 1'b1;
                        w_digits_nxt = w_shift_up;
                        // A full buffer drops its oldest digit and stays full.
                        w_len_nxt    = (r_len == MAX_LEN) ? MAX_LEN : r_len + ONE_LEN;
                        w_next_state = ST_ENTRY;
                    end else if (key_code == KEY_BACK) begin
                        // Backspace on an empty buffer is silently ignored.
                        if (r_len != '0) begin
                            w_accept     = 1'b1;
                            w_digits_nxt = w_shift_down;
                            w_len_nxt    = r_len - ONE_LEN;
                            w_next_state = (r_len == ONE_LEN) ? ST_IDLE : ST_ENTRY;
                        end
                    end else if (key_code == KEY_CLEAR) begin
                        w_accept     = 1'b1;
                        w_digits_nxt = EMPTY;
                        w_len_nxt    = '0;
                        w_next_state = ST_IDLE;
                    end else if (key_code == KEY_ENTER) begin
                        w_accept = 1'b1;
                        if ((r_len >= MIN_LEN) && (r_len != '0)) begin
                            w_next_state = ST_READY;
                        end else begin
                            w_err_nxt    = 1'b1;
                            w_digits_nxt = EMPTY;
                            w_len_nxt    = '0;
                            w_next_state = ST_IDLE;
                        end
                    end
                end

                // An accepted key always wins over expiry and restarts the timer;
                // unknown codes fall through and leave it counting.
                if (w_accept) begin
                    w_timer_nxt = '0;
                end else if (TIMER_EN && (r_state == ST_ENTRY)) begin
                    if (r_timer == TMR_LAST) begin
                        w_timeout_nxt = 1'b1;
                        w_digits_nxt  = EMPTY;
                        w_len_nxt     = '0;
                        w_timer_nxt   = '0;
                        w_next_state  = ST_IDLE;
                    end else begin
                        w_timer_nxt = r_timer + TMR_W'(1);
                    end
                end
            end

            ST_READY: begin
                // Key events are dropped here; only the consumer's ack frees the buffer.
                w_timer_nxt = '0;
                if (pin_ack) begin
                    w_digits_nxt = EMPTY;
                    w_len_nxt    = '0;
                    w_next_state = ST_IDLE;
                end
            end

            default: begin
                w_digits_nxt = EMPTY;
                w_len_nxt    = '0;
                w_timer_nxt  = '0;
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Datapath and output registers, all loaded from the decided next values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the digit buffer is a handful of flops, not a RAM, so it is reset like any other register.
            r_digits  <= EMPTY;
            r_len     <= '0;
            r_timer   <= '0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_err     <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_digits  <= w_digits_nxt;
            r_len     <= w_len_nxt;
            r_timer   <= w_timer_nxt;
            r_valid   <= (w_next_state == ST_READY);
            r_busy    <= (w_next_state == ST_ENTRY);
            r_err     <= w_err_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    assign pin_digits = r_digits;
    assign pin_len    = r_len;
    assign pin_valid  = r_valid;
    assign busy       = r_busy;
    assign err        = r_err;
    assign timeout    = r_timeout;

endmodule

// File: tb/tb_montar_pin_param.sv
// Self-checking bench for montar_pin_param (MAX 4, MIN 4, timeout 20).
// Directed scenarios check fixed expected values; a randomized run is checked
// against a queue-based reference model of the PIN-entry rules.
module tb_montar_pin_param;

    localparam int MAXD = 4;
    localparam int MIND = 4;
    localparam int TOUT = 20;
    localparam int LW   = $clog2(MAXD + 1);
    localparam int OW   = 4*MAXD + LW + 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            key_valid;
    logic [3:0]      key_code;
    logic            pin_ack;
    logic [4*MAXD-1:0] pin_digits;
    logic [LW-1:0]   pin_len;
    logic            pin_valid;
    logic            busy;
    logic            err;
    logic            timeout;

    int n_vec  = 0;
    int n_fail = 0;

    // Reference model state: digits newest-first, READY flag, quiet-cycle count.
    int mq[$];
    bit m_ready;
    int m_quiet;
    bit m_kv_prev;
    bit m_err;
    bit m_to;

    montar_pin_param #(
        .MAX_DIGITS     (MAXD),
        .MIN_DIGITS     (MIND),
        .TIMEOUT_CYCLES (TOUT),
        .KEY_BACK       (4'hA),
        .KEY_CLEAR      (4'hE),
        .KEY_ENTER      (4'hF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .pin_ack    (pin_ack),
        .pin_digits (pin_digits),
        .pin_len    (pin_len),
        .pin_valid  (pin_valid),
        .busy       (busy),
        .err        (err),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [OW-1:0] outs();
        return {pin_digits, pin_len, pin_valid, busy, err, timeout};
    endfunction

    function automatic logic [OW-1:0] pack(logic [4*MAXD-1:0] d, int len, bit v, bit b, bit e, bit t);
        return {d, LW'(len), v, b, e, t};
    endfunction

    task automatic model_reset();
        mq.delete();
        m_ready   = 1'b0;
        m_quiet   = 0;
        m_kv_prev = 1'b1;
        m_err     = 1'b0;
        m_to      = 1'b0;
    endtask

    // One clock of the PIN-entry rules, in terms of a digit list.
    task automatic model_step(input bit kv, input logic [3:0] code, input bit ack);
        bit ev;
        bit acc;
        ev        = kv && !m_kv_prev;
        acc       = 1'b0;
        m_kv_prev = kv;
        m_err     = 1'b0;
        m_to      = 1'b0;
        if (m_ready) begin
            if (ack) begin
                mq.delete();
                m_ready = 1'b0;
            end
        end else begin
            if (ev) begin
                if (code <= 4'd9) begin
                    mq.push_front(int'(code));
                    if (mq.size() > MAXD) void'(mq.pop_back());
                    acc = 1'b1;
                end else if (code == 4'hA) begin
                    if (mq.size() > 0) begin
                        void'(mq.pop_front());
                        acc = 1'b1;
                    end
                end else if (code == 4'hE) begin
                    mq.delete();
                    acc = 1'b1;
                end else if (code == 4'hF) begin
                    acc = 1'b1;
                    if (mq.size() >= MIND && mq.size() > 0) begin
                        m_ready = 1'b1;
                    end else begin
                        m_err = 1'b1;
                        mq.delete();
                    end
                end
            end
            if (acc) begin
                m_quiet = 0;
            end else if (mq.size() > 0) begin
                m_quiet++;
                if (m_quiet == TOUT) begin
                    m_to    = 1'b1;
                    mq.delete();
                    m_quiet = 0;
                end
            end
        end
    endtask

    function automatic logic [OW-1:0] model_outs();
        logic [4*MAXD-1:0] d;
        d = '1;
        for (int i = 0; i < mq.size(); i++) d[4*i +: 4] = 4'(mq[i]);
        return pack(d, mq.size(), m_ready, !m_ready && mq.size() > 0, m_err, m_to);
    endfunction

    // Drive inputs at the falling edge, let one rising edge pass, return at the next falling edge.
    task automatic cycle(input bit kv, input logic [3:0] code, input bit ack);
        key_valid = kv;
        key_code  = code;
        pin_ack   = ack;
        @(posedge clk);
        model_step(kv, code, ack);
        @(negedge clk);
    endtask

    task automatic press(input logic [3:0] code);
        cycle(1'b1, code, 1'b0);
        cycle(1'b0, code, 1'b0);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_vec++;
        if (outs() !== pack(16'hFFFF, 0, 0, 0, 0, 0)) begin
            n_fail++;
            $display("FAIL reset_values: got %h expected %h", outs(), pack(16'hFFFF, 0, 0, 0, 0, 0));
        end
        rst = 1'b1;
        cycle(1'b0, 4'h0, 1'b0);
        n_vec++;
        if (outs() !== pack(16'hFFFF, 0, 0, 0, 0, 0)) begin
            n_fail++;
            $display("FAIL idle_after_reset: got %h expected %h", outs(), pack(16'hFFFF, 0, 0, 0, 0, 0));
        end
    endtask

    task automatic test_ready_ack();
        press(4'h1); press(4'h2); press(4'h3); press(4'h4);
        n_vec++;
        if (outs() !== pack(16'h1234, 4, 0, 1, 0, 0)) begin
            n_fail++;
            $display("FAIL entry_1234: got %h expected %h", outs(), pack(16'h1234, 4, 0, 1, 0, 0));
        end
        press(4'hF);
        n_vec++;
        if (outs() !== pack(16'h1234, 4, 1, 0, 0, 0)) begin
            n_fail++;
            $display("FAIL ready_1234: got %h expected %h", outs(), pack(16'h1234, 4, 1, 0, 0, 0));
        end
        press(4'h5);
        n_vec++;
        if (outs() !== pack(16'h1234, 4, 1, 0, 0, 0)) begin
            n_fail++;
            $display("FAIL ready_ignores_key: got %h expected %h", outs(), pack(16'h1234, 4, 1, 0, 0, 0));
        end
        cycle(1'b0, 4'h0, 1'b1);
        n_vec++;
        if (outs() !== pack(16'hFFFF, 0, 0, 0, 0, 0)) begin
            n_fail++;
            $display("FAIL ack_frees: got %h expected %h", outs(), pack(16'hFFFF, 0, 0, 0, 0, 0));
        end
        // ack outside READY must do nothing
        press(4'h8);
        cycle(1'b0, 4'h0, 1'b1);
        n_vec++;
        if (outs() !== pack(16'hFFF8, 1, 0, 1, 0, 0)) begin
            n_fail++;
            $display("FAIL ack_in_entry: got %h expected %h", outs(), pack(16'hFFF8, 1, 0, 1, 0, 0));
        end
        press(4'hE);
    endtask

    task automatic test_overflow();
        press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'h5); press(4'hF);
        n_vec++;
        if (outs() !== pack(16'h2345, 4, 1, 0, 0, 0)) begin
            n_fail++;
            $display("FAIL overflow: got %h expected %h", outs(), pack(16'h2345, 4, 1, 0, 0, 0));
        end
        cycle(1'b0, 4'h0, 1'b1);
    endtask

    task automatic test_backspace();
        press(4'h7); press(4'h8); press(4'hA);
        n_vec++;
        if (outs() !== pack(16'hFFF7, 1, 0, 1, 0, 0)) begin
            n_fail++;
            $display("FAIL back_one: got %h expected %h", outs(), pack(16'hFFF7, 1, 0, 1, 0, 0));
        end
        press(4'hA);
        n_vec++;
        if (outs() !== pack(16'hFFFF, 0, 0, 0, 0, 0)) begin
            n_fail++;
            $display("FAIL back_to_idle: got %h expected %h", outs(), pack(16'hFFFF, 0, 0, 0, 0, 0));
        end
        cycle(1'b1, 4'hA, 1'b0);
        n_vec++;
        if (outs() !== pack(16'hFFFF, 0, 0, 0, 0, 0)) begin
            n_fail++;
            $display("FAIL back_at_empty: got %h expected %h", outs(), pack(16'hFFFF, 0, 0, 0, 0, 0));
        end
        cycle(1'b0, 4'hA, 1'b0);
    endtask

    task automatic test_short_enter();
        press(4'h1); press(4'h2);
        cycle(1'b1, 4'hF, 1'b0);
        n_vec++;
        if (outs() !== pack(16'hFFFF, 0, 0, 0, 1, 0)) begin
            n_fail++;
            $display("FAIL short_enter_err: got %h expected %h", outs(), pack(16'hFFFF, 0, 0, 0, 1, 0));
        end
        cycle(1'b0, 4'hF, 1'b0);
        n_vec++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_one_cycle: got %b expected 0", err);
        end
        press(4'h3); press(4'hE);
        n_vec++;
        if (outs() !== pack(16'hFFFF, 0, 0, 0, 0, 0)) begin
            n_fail++;
            $display("FAIL clear_mid_entry: got %h expected %h", outs(), pack(16'hFFFF, 0, 0, 0, 0, 0));
        end
        press(4'h4); press(4'hB);
        n_vec++;
        if (outs() !== pack(16'hFFF4, 1, 0, 1, 0, 0)) begin
            n_fail++;
            $display("FAIL unknown_key_noop: got %h expected %h", outs(), pack(16'hFFF4, 1, 0, 1, 0, 0));
        end
        press(4'hE);
    endtask

    task automatic test_timeout();
        cycle(1'b1, 4'h9, 1'b0);
        repeat (TOUT - 1) cycle(1'b0, 4'h0, 1'b0);
        n_vec++;
        if (outs() !== pack(16'hFFF9, 1, 0, 1, 0, 0)) begin
            n_fail++;
            $display("FAIL before_timeout: got %h expected %h", outs(), pack(16'hFFF9, 1, 0, 1, 0, 0));
        end
        cycle(1'b0, 4'h0, 1'b0);
        n_vec++;
        if (outs() !== pack(16'hFFFF, 0, 0, 0, 0, 1)) begin
            n_fail++;
            $display("FAIL timeout_pulse: got %h expected %h", outs(), pack(16'hFFFF, 0, 0, 0, 0, 1));
        end
        cycle(1'b1, 4'h9, 1'b0);
        repeat (TOUT - 1) cycle(1'b0, 4'h0, 1'b0);
        cycle(1'b1, 4'h3, 1'b0);
        n_vec++;
        if (outs() !== pack(16'hFF93, 2, 0, 1, 0, 0)) begin
            n_fail++;
            $display("FAIL key_beats_expiry: got %h expected %h", outs(), pack(16'hFF93, 2, 0, 1, 0, 0));
        end
        cycle(1'b0, 4'h0, 1'b0);
        n_vec++;
        if (timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL timer_restarted: got %b expected 0", timeout);
        end
        press(4'hE);
    endtask

    task automatic test_async_reset();
        press(4'h1); press(4'h2);
        cycle(1'b1, 4'h3, 1'b0);
        n_vec++;
        if (pin_len !== LW'(3)) begin
            n_fail++;
            $display("FAIL len_before_reset: got %0d expected 3", pin_len);
        end
        #2 rst = 1'b0;
        #1;
        model_reset();
        n_vec++;
        if (outs() !== pack(16'hFFFF, 0, 0, 0, 0, 0)) begin
            n_fail++;
            $display("FAIL async_reset: got %h expected %h", outs(), pack(16'hFFFF, 0, 0, 0, 0, 0));
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (3) cycle(1'b1, 4'h3, 1'b0);
        n_vec++;
        if (outs() !== pack(16'hFFFF, 0, 0, 0, 0, 0)) begin
            n_fail++;
            $display("FAIL held_key_no_event: got %h expected %h", outs(), pack(16'hFFFF, 0, 0, 0, 0, 0));
        end
        cycle(1'b0, 4'h3, 1'b0);
        cycle(1'b1, 4'h6, 1'b0);
        n_vec++;
        if (outs() !== pack(16'hFFF6, 1, 0, 1, 0, 0)) begin
            n_fail++;
            $display("FAIL repress_after_reset: got %h expected %h", outs(), pack(16'hFFF6, 1, 0, 1, 0, 0));
        end
        cycle(1'b0, 4'h6, 1'b0);
        press(4'h7); press(4'h8); press(4'h9); press(4'hF);
        #2 rst = 1'b0;
        #1;
        model_reset();
        n_vec++;
        if (outs() !== pack(16'hFFFF, 0, 0, 0, 0, 0)) begin
            n_fail++;
            $display("FAIL reset_from_ready: got %h expected %h", outs(), pack(16'hFFFF, 0, 0, 0, 0, 0));
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_random();
        bit         kv;
        logic [3:0] code;
        bit         ack;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                kv = 1'b0;
                repeat (TOUT + 5) begin
                    cycle(1'b0, 4'h0, 1'b0);
                    n_vec++;
                    if (outs() !== model_outs()) begin
                        n_fail++;
                        $display("FAIL random_idle: got %h expected %h", outs(), model_outs());
                    end
                end
            end
            kv   = 1'($urandom_range(0, 1));
            code = ($urandom_range(0, 9) < 7) ? 4'($urandom_range(0, 9)) : 4'($urandom_range(10, 15));
            ack  = ($urandom_range(0, 7) == 0);
            cycle(kv, code, ack);
            n_vec++;
            if (outs() !== model_outs()) begin
                n_fail++;
                $display("FAIL random_step %0d: got %h expected %h", n, outs(), model_outs());
            end
        end
    endtask

    initial begin
        rst       = 1'b0;
        key_valid = 1'b0;
        key_code  = 4'h0;
        pin_ack   = 1'b0;
        model_reset();
        test_reset();
        test_ready_ack();
        test_overflow();
        test_backspace();
        test_short_enter();
        test_timeout();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
